rs_dispatch_ctrl: RTL and testbench

Sequential reservation-station controller for the ALU path. It accepts decoded instructions from the issue stage, holds them in `RS_SIZE` entries, and snoops the two CDB buses to resolve operands. Each cycle it dispatches one fully-ready entry to the ALU. Free-slot and ready-slot selection is lowest-index-first. This block owns the entry state, the busy/prepared vectors and the dispatch register, and reports `rs_full` back to the issue stage.

---
 rtl/rs_dispatch_ctrl_if.sv | 45 ++++
 rtl/rs_dispatch_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_rs_dispatch_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_dispatch_ctrl_if.sv
// Issue / CDB / ALU-dispatch bundle for the ALU reservation station.
// master: issue stage, CDB producers and ALU side (drives issue/CDB, sees rs_full and dispatch).
// slave : rs_dispatch_ctrl (consumes issue/CDB, drives rs_full and the alu_* payload).
interface rs_dispatch_ctrl_if #(
  parameter int unsigned ROB_BIT = 5,
  parameter int unsigned OP_BIT  = 5
);
  logic               issue_valid;
  logic [OP_BIT-1:0]  issue_op;
  logic [ROB_BIT-1:0] issue_rob_id;
  logic [31:0]        issue_vj;
  logic [31:0]        issue_vk;
  logic               issue_qj_busy;
  logic               issue_qk_busy;
  logic [ROB_BIT-1:0] issue_qj;
  logic [ROB_BIT-1:0] issue_qk;
  logic               cdb_alu_valid;
  logic [ROB_BIT-1:0] cdb_alu_rob_id;
  logic [31:0]        cdb_alu_value;
  logic               cdb_lsb_valid;
  logic [ROB_BIT-1:0] cdb_lsb_rob_id;
  logic [31:0]        cdb_lsb_value;
  logic               rs_full;
  logic               alu_valid;
  logic [OP_BIT-1:0]  alu_op;
  logic [31:0]        alu_v1;
  logic [31:0]        alu_v2;
  logic [ROB_BIT-1:0] alu_rob_id;

  modport master (
    output issue_valid, issue_op, issue_rob_id, issue_vj, issue_vk,
           issue_qj_busy, issue_qk_busy, issue_qj, issue_qk,
           cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value,
           cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value,
    input  rs_full, alu_valid, alu_op, alu_v1, alu_v2, alu_rob_id
  );

  modport slave (
    input  issue_valid, issue_op, issue_rob_id, issue_vj, issue_vk,
           issue_qj_busy, issue_qk_busy, issue_qj, issue_qk,
           cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value,
           cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value,
    output rs_full, alu_valid, alu_op, alu_v1, alu_v2, alu_rob_id
  );
endinterface

// File: rtl/rs_dispatch_ctrl.sv
// ALU reservation station: holds RS_SIZE issued instructions, snoops both CDBs
// to resolve operands, dispatches the lowest-index ready entry each cycle.
// Ports: clk_in, rst_in (sync, active-high), rdy_in (global enable),
//        clear (misprediction flush), bus (rs_dispatch_ctrl_if.slave).
module rs_dispatch_ctrl #(
  parameter int unsigned RS_SIZE = 8,
  parameter int unsigned RS_BIT  = 3,
  parameter int unsigned ROB_BIT = 5,
  parameter int unsigned OP_BIT  = 5
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  rs_dispatch_ctrl_if.slave bus
);

  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] qj_busy_q, qj_busy_d;
  logic [RS_SIZE-1:0] qk_busy_q, qk_busy_d;
  logic [OP_BIT-1:0]  op_q  [RS_SIZE];
  logic [OP_BIT-1:0]  op_d  [RS_SIZE];
  logic [ROB_BIT-1:0] rob_q [RS_SIZE];
  logic [ROB_BIT-1:0] rob_d [RS_SIZE];
  logic [ROB_BIT-1:0] qj_q  [RS_SIZE];
  logic [ROB_BIT-1:0] qj_d  [RS_SIZE];
  logic [ROB_BIT-1:0] qk_q  [RS_SIZE];
  logic [ROB_BIT-1:0] qk_d  [RS_SIZE];
  logic [31:0]        vj_q  [RS_SIZE];
  logic [31:0]        vj_d  [RS_SIZE];
  logic [31:0]        vk_q  [RS_SIZE];
  logic [31:0]        vk_d  [RS_SIZE];

  logic               alu_valid_q, alu_valid_d;
  logic [OP_BIT-1:0]  alu_op_q, alu_op_d;
  logic [31:0]        alu_v1_q, alu_v1_d;
  logic [31:0]        alu_v2_q, alu_v2_d;
  logic [ROB_BIT-1:0] alu_rob_q, alu_rob_d;

  logic [RS_SIZE-1:0] prepared;
  logic [RS_BIT-1:0]  free_idx;
  logic [RS_BIT-1:0]  disp_idx;
  logic               disp_any;
  logic               rs_full;
  logic               do_issue;
  logic [31:0]        iss_vj, iss_vk;
  logic               iss_qj_busy, iss_qk_busy;

  assign prepared = busy_q & ~qj_busy_q & ~qk_busy_q;
  assign rs_full  = &busy_q;
  assign do_issue = bus.issue_valid & ~rs_full & rdy_in & ~clear;

  // Lowest-index free slot and lowest-index prepared slot (descending scan, last hit wins)
  always_comb begin
    free_idx = '0;
    disp_idx = '0;
    disp_any = 1'b0;
    for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = RS_BIT'(i);
      if (prepared[i]) begin
        disp_idx = RS_BIT'(i);
        disp_any = 1'b1;
      end
    end
  end

  // Issue-time bypass: a pending operand whose producer broadcasts this cycle; ALU CDB first
  always_comb begin
    iss_vj      = bus.issue_vj;
    iss_qj_busy = bus.issue_qj_busy;
    iss_vk      = bus.issue_vk;
    iss_qk_busy = bus.issue_qk_busy;
    if (bus.issue_qj_busy && bus.cdb_alu_valid && bus.cdb_alu_rob_id == bus.issue_qj) begin
      iss_vj = bus.cdb_alu_value; iss_qj_busy = 1'b0;
    end else if (bus.issue_qj_busy && bus.cdb_lsb_valid && bus.cdb_lsb_rob_id == bus.issue_qj) begin
      iss_vj = bus.cdb_lsb_value; iss_qj_busy = 1'b0;
    end
    if (bus.issue_qk_busy && bus.cdb_alu_valid && bus.cdb_alu_rob_id == bus.issue_qk) begin
      iss_vk = bus.cdb_alu_value; iss_qk_busy = 1'b0;
    end else if (bus.issue_qk_busy && bus.cdb_lsb_valid && bus.cdb_lsb_rob_id == bus.issue_qk) begin
      iss_vk = bus.cdb_lsb_value; iss_qk_busy = 1'b0;
    end
  end

  // Next state: flush, or snoop + dispatch + issue when enabled
  always_comb begin
    busy_d      = busy_q;
    qj_busy_d   = qj_busy_q;
    qk_busy_d   = qk_busy_q;
    op_d        = op_q;
    rob_d       = rob_q;
    qj_d        = qj_q;
    qk_d        = qk_q;
    vj_d        = vj_q;
    vk_d        = vk_q;
    alu_valid_d = 1'b0;
    alu_op_d    = alu_op_q;
    alu_v1_d    = alu_v1_q;
    alu_v2_d    = alu_v2_q;
    alu_rob_d   = alu_rob_q;
    if (clear) begin
      busy_d    = '0;
      qj_busy_d = '0;
      qk_busy_d = '0;
      alu_op_d  = '0;
      alu_v1_d  = '0;
      alu_v2_d  = '0;
      alu_rob_d = '0;
    end else if (rdy_in) begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        if (busy_q[i] && qj_busy_q[i]) begin
          if (bus.cdb_alu_valid && bus.cdb_alu_rob_id == qj_q[i]) begin
            vj_d[i] = bus.cdb_alu_value; qj_busy_d[i] = 1'b0;
          end else if (bus.cdb_lsb_valid && bus.cdb_lsb_rob_id == qj_q[i]) begin
            vj_d[i] = bus.cdb_lsb_value; qj_busy_d[i] = 1'b0;
          end
        end
        if (busy_q[i] && qk_busy_q[i]) begin
          if (bus.cdb_alu_valid && bus.cdb_alu_rob_id == qk_q[i]) begin
            vk_d[i] = bus.cdb_alu_value; qk_busy_d[i] = 1'b0;
          end else if (bus.cdb_lsb_valid && bus.cdb_lsb_rob_id == qk_q[i]) begin
            vk_d[i] = bus.cdb_lsb_value; qk_busy_d[i] = 1'b0;
          end
        end
      end
      if (disp_any) begin
        alu_valid_d      = 1'b1;
        alu_op_d         = op_q[disp_idx];
        alu_v1_d         = vj_q[disp_idx];
        alu_v2_d         = vk_q[disp_idx];
        alu_rob_d        = rob_q[disp_idx];
        busy_d[disp_idx] = 1'b0;
      end
      // free_idx comes from registered busy, so it never aliases the dispatched slot
      if (do_issue) begin
        busy_d[free_idx]    = 1'b1;
        op_d[free_idx]      = bus.issue_op;
        rob_d[free_idx]     = bus.issue_rob_id;
        qj_d[free_idx]      = bus.issue_qj;
        qk_d[free_idx]      = bus.issue_qk;
        vj_d[free_idx]      = iss_vj;
        vk_d[free_idx]      = iss_vk;
        qj_busy_d[free_idx] = iss_qj_busy;
        qk_busy_d[free_idx] = iss_qk_busy;
      end
    end
  end

  // Control flags and dispatch register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q      <= '0;
      qj_busy_q   <= '0;
      qk_busy_q   <= '0;
      alu_valid_q <= 1'b0;
      alu_op_q    <= '0;
      alu_v1_q    <= '0;
      alu_v2_q    <= '0;
      alu_rob_q   <= '0;
    end else begin
      busy_q      <= busy_d;
      qj_busy_q   <= qj_busy_d;
      qk_busy_q   <= qk_busy_d;
      alu_valid_q <= alu_valid_d;
      alu_op_q    <= alu_op_d;
      alu_v1_q    <= alu_v1_d;
      alu_v2_q    <= alu_v2_d;
      alu_rob_q   <= alu_rob_d;
    end
  end

  // Entry payload; only meaningful while busy, so no reset
  always_ff @(posedge clk_in) begin
    op_q  <= op_d;
    rob_q <= rob_d;
    qj_q  <= qj_d;
    qk_q  <= qk_d;
    vj_q  <= vj_d;
    vk_q  <= vk_d;
  end

  assign bus.rs_full    = rs_full;
  assign bus.alu_valid  = alu_valid_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_v1     = alu_v1_q;
  assign bus.alu_v2     = alu_v2_q;
  assign bus.alu_rob_id = alu_rob_q;

endmodule

// File: tb/tb_rs_dispatch_ctrl.sv
module tb_rs_dispatch_ctrl;
  localparam int unsigned RS_SIZE = 8;
  localparam int unsigned RS_BIT  = 3;
  localparam int unsigned ROB_BIT = 5;
  localparam int unsigned OP_BIT  = 5;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clear;
  int   tests = 0;
  int   fails = 0;

  rs_dispatch_ctrl_if #(.ROB_BIT(ROB_BIT), .OP_BIT(OP_BIT)) bus ();

  rs_dispatch_ctrl #(.RS_SIZE(RS_SIZE), .RS_BIT(RS_BIT), .ROB_BIT(ROB_BIT), .OP_BIT(OP_BIT)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: a table of waiting instructions plus the last dispatch
  typedef struct {
    bit        busy;
    bit [4:0]  op, rob, qj, qk;
    bit [31:0] vj, vk;
    bit        qjb, qkb;
  } ent_t;

  ent_t      m [RS_SIZE];
  bit        e_valid;
  bit [4:0]  e_op, e_rob;
  bit [31:0] e_v1, e_v2;

  function automatic bit cdb_hit(input bit [4:0] tag, output bit [31:0] v);
    v = 32'h0;
    if (bus.cdb_alu_valid && bus.cdb_alu_rob_id == tag) begin v = bus.cdb_alu_value; return 1'b1; end
    if (bus.cdb_lsb_valid && bus.cdb_lsb_rob_id == tag) begin v = bus.cdb_lsb_value; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic bit model_full();
    for (int i = 0; i < int'(RS_SIZE); i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    ent_t      old [RS_SIZE];
    int        fr, dp;
    bit        full;
    bit [31:0] v;
    if (rst_in || clear) begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        m[i].busy = 0; m[i].qjb = 0; m[i].qkb = 0;
      end
      e_valid = 0; e_op = 0; e_rob = 0; e_v1 = 0; e_v2 = 0;
      return;
    end
    e_valid = 0;
    if (!rdy_in) return;
    old  = m;
    full = model_full();
    fr = -1; dp = -1;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      if (!old[i].busy && fr < 0) fr = i;
      if (old[i].busy && !old[i].qjb && !old[i].qkb && dp < 0) dp = i;
    end
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      if (old[i].busy && old[i].qjb && cdb_hit(old[i].qj, v)) begin m[i].vj = v; m[i].qjb = 0; end
      if (old[i].busy && old[i].qkb && cdb_hit(old[i].qk, v)) begin m[i].vk = v; m[i].qkb = 0; end
    end
    if (dp >= 0) begin
      e_valid = 1; e_op = old[dp].op; e_v1 = old[dp].vj; e_v2 = old[dp].vk; e_rob = old[dp].rob;
      m[dp].busy = 0;
    end
    if (bus.issue_valid && !full) begin
      m[fr].busy = 1;
      m[fr].op  = bus.issue_op;  m[fr].rob = bus.issue_rob_id;
      m[fr].qj  = bus.issue_qj;  m[fr].qk  = bus.issue_qk;
      m[fr].vj  = bus.issue_vj;  m[fr].vk  = bus.issue_vk;
      m[fr].qjb = bus.issue_qj_busy; m[fr].qkb = bus.issue_qk_busy;
      if (m[fr].qjb && cdb_hit(m[fr].qj, v)) begin m[fr].vj = v; m[fr].qjb = 0; end
      if (m[fr].qkb && cdb_hit(m[fr].qk, v)) begin m[fr].vk = v; m[fr].qkb = 0; end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: update the model, clock the DUT, compare all outputs
  task automatic step(input string tag);
    model_step();
    @(posedge clk_in);
    #1;
    chk({tag, ".alu_valid"}, 32'(bus.alu_valid), 32'(e_valid));
    chk({tag, ".alu_op"},    32'(bus.alu_op),    32'(e_op));
    chk({tag, ".alu_v1"},    bus.alu_v1,         e_v1);
    chk({tag, ".alu_v2"},    bus.alu_v2,         e_v2);
    chk({tag, ".alu_rob"},   32'(bus.alu_rob_id), 32'(e_rob));
    chk({tag, ".rs_full"},   32'(bus.rs_full),   32'(model_full()));
  endtask

  task automatic idle();
    bus.issue_valid = 0; bus.issue_op = 0; bus.issue_rob_id = 0;
    bus.issue_vj = 0; bus.issue_vk = 0;
    bus.issue_qj_busy = 0; bus.issue_qk_busy = 0; bus.issue_qj = 0; bus.issue_qk = 0;
    bus.cdb_alu_valid = 0; bus.cdb_alu_rob_id = 0; bus.cdb_alu_value = 0;
    bus.cdb_lsb_valid = 0; bus.cdb_lsb_rob_id = 0; bus.cdb_lsb_value = 0;
  endtask

  task automatic issue(input bit [4:0] op, input bit [4:0] rob, input bit [31:0] vj, input bit [31:0] vk,
                       input bit qjb, input bit [4:0] qj, input bit qkb, input bit [4:0] qk);
    bus.issue_valid = 1; bus.issue_op = op; bus.issue_rob_id = rob;
    bus.issue_vj = vj; bus.issue_vk = vk;
    bus.issue_qj_busy = qjb; bus.issue_qj = qj; bus.issue_qk_busy = qkb; bus.issue_qk = qk;
  endtask

  task automatic cdb_alu(input bit [4:0] tag, input bit [31:0] val);
    bus.cdb_alu_valid = 1; bus.cdb_alu_rob_id = tag; bus.cdb_alu_value = val;
  endtask

  task automatic cdb_lsb(input bit [4:0] tag, input bit [31:0] val);
    bus.cdb_lsb_valid = 1; bus.cdb_lsb_rob_id = tag; bus.cdb_lsb_value = val;
  endtask

  initial begin
    rst_in = 1; rdy_in = 1; clear = 0;
    idle();
    step("rst0");
    step("rst1");
    chk("rst.valid", 32'(bus.alu_valid), 0);
    chk("rst.full",  32'(bus.rs_full), 0);
    chk("rst.v1",    bus.alu_v1, 0);
    rst_in = 0;

    // Fully-ready issue dispatches two edges later, one-cycle pulse
    issue(3, 2, 5, 7, 0, 0, 0, 0);
    step("t1.e1");
    idle();
    step("t1.e2");
    chk("t1.valid", 32'(bus.alu_valid), 1);
    chk("t1.op",    32'(bus.alu_op), 3);
    chk("t1.v1",    bus.alu_v1, 5);
    chk("t1.v2",    bus.alu_v2, 7);
    chk("t1.rob",   32'(bus.alu_rob_id), 2);
    step("t1.e3");
    chk("t1.pulse", 32'(bus.alu_valid), 0);

    // Pending operand resolved by LSB CDB
    issue(4, 6, 32'hdead, 11, 1, 4, 0, 0);
    step("t2.iss");
    idle();
    step("t2.w0");
    step("t2.w1");
    chk("t2.wait", 32'(bus.alu_valid), 0);
    cdb_lsb(4, 32'h1234);
    step("t2.cdb");
    idle();
    step("t2.disp");
    chk("t2.valid", 32'(bus.alu_valid), 1);
    chk("t2.v1",    bus.alu_v1, 32'h1234);
    chk("t2.rob",   32'(bus.alu_rob_id), 6);
    step("t2.end");

    // Same-cycle bypass
    issue(4, 7, 0, 11, 1, 4, 0, 0);
    cdb_lsb(4, 32'h5678);
    step("t2b.iss");
    idle();
    step("t2b.disp");
    chk("t2b.valid", 32'(bus.alu_valid), 1);
    chk("t2b.v1",    bus.alu_v1, 32'h5678);
    step("t2b.end");

    // Fill all entries, ignored issue while full, then drain in index order
    for (int i = 0; i < 8; i++) begin
      issue(1, 5'(10 + i), 32'(i), 32'(100 + i), 1, 9, 0, 0);
      step($sformatf("t3.fill%0d", i));
    end
    chk("t3.full", 32'(bus.rs_full), 1);
    issue(2, 30, 1, 2, 0, 0, 0, 0);
    step("t3.ignored");
    chk("t3.full_hold", 32'(bus.rs_full), 1);
    idle();
    cdb_alu(9, 32'h99);
    step("t3.cdb");
    idle();
    for (int i = 0; i < 8; i++) begin
      step($sformatf("t3.drain%0d", i));
      chk($sformatf("t3.rob%0d", i), 32'(bus.alu_rob_id), 32'(10 + i));
      chk($sformatf("t3.val%0d", i), 32'(bus.alu_valid), 1);
      if (i == 0) chk("t3.full_drop", 32'(bus.rs_full), 0);
    end
    step("t3.empty");
    chk("t3.after", 32'(bus.alu_valid), 0);

    // Entries 1 and 3 ready together; new issue lands in freed slot 0
    issue(1, 1, 0, 0, 1, 20, 0, 0); step("t4.i0");
    issue(1, 2, 0, 0, 1, 21, 0, 0); step("t4.i1");
    issue(1, 3, 0, 0, 1, 22, 0, 0); step("t4.i2");
    issue(1, 4, 0, 0, 1, 21, 0, 0); step("t4.i3");
    idle();
    cdb_alu(20, 32'h20); step("t4.c20");
    idle();
    cdb_alu(21, 32'h21); step("t4.c21");
    chk("t4.rob_s0", 32'(bus.alu_rob_id), 1);
    idle();
    issue(5, 25, 1, 1, 1, 22, 0, 0);
    step("t4.d1");
    chk("t4.rob_s1", 32'(bus.alu_rob_id), 2);
    idle();
    step("t4.d3");
    chk("t4.rob_s3", 32'(bus.alu_rob_id), 4);
    cdb_lsb(22, 32'h22); step("t4.c22");
    idle();
    step("t4.d0");
    chk("t4.rob_new0", 32'(bus.alu_rob_id), 25);
    step("t4.d2");
    chk("t4.rob_s2", 32'(bus.alu_rob_id), 3);
    step("t4.end");

    // Clear beats a simultaneous issue
    for (int i = 0; i < 5; i++) begin
      issue(2, 5'(i), 0, 0, 1, 31, 0, 0);
      step($sformatf("t5.fill%0d", i));
    end
    issue(6, 17, 8, 9, 0, 0, 0, 0);
    clear = 1;
    step("t5.clear");
    clear = 0;
    idle();
    chk("t5.full",  32'(bus.rs_full), 0);
    chk("t5.valid", 32'(bus.alu_valid), 0);
    chk("t5.rob",   32'(bus.alu_rob_id), 0);
    step("t5.none");
    chk("t5.nowrite", 32'(bus.alu_valid), 0);

    // rdy_in low freezes dispatch
    issue(7, 12, 3, 4, 0, 0, 0, 0);
    step("t6.iss");
    idle();
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      step($sformatf("t6.hold%0d", i));
      chk($sformatf("t6.held%0d", i), 32'(bus.alu_valid), 0);
    end
    rdy_in = 1;
    step("t6.go");
    chk("t6.valid", 32'(bus.alu_valid), 1);
    chk("t6.rob",   32'(bus.alu_rob_id), 12);
    step("t6.end");

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      idle();
      rdy_in = ($urandom_range(0, 9) != 0);
      clear  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) < 6)
        issue(5'($urandom), 5'($urandom), $urandom, $urandom,
              1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)));
      if (rdy_in && $urandom_range(0, 9) < 4) cdb_alu(5'($urandom_range(0, 7)), $urandom);
      if (rdy_in && $urandom_range(0, 9) < 4) cdb_lsb(5'($urandom_range(0, 7)), $urandom);
      step($sformatf("rnd%0d", n));
    end
    clear = 0; rdy_in = 1;
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
